// File: rtl/prog_xfade_if.sv
// Bus between the CSR/audio side and the program crossfader: control requests,
// the sample stream in and out, and the committed program/table/mix outputs.
interface prog_xfade_if;
  logic        [1:0]  req_tbl;
  logic        [5:0]  req_prog;
  logic        [11:0] req_mix;
  logic               ena;
  logic signed [15:0] in_l;
  logic signed [15:0] in_r;
  logic signed [15:0] out_l;
  logic signed [15:0] out_r;
  logic               valid;
  logic        [1:0]  tbl;
  logic        [5:0]  prog;
  logic        [11:0] mix;

  modport master (
    output req_tbl, req_prog, req_mix, ena, in_l, in_r,
    input  out_l, out_r, valid, tbl, prog, mix
  );

  modport slave (
    input  req_tbl, req_prog, req_mix, ena, in_l, in_r,
    output out_l, out_r, valid, tbl, prog, mix
  );
endinterface

// File: rtl/prog_xfade.sv
// Click-free program switcher: fades audio to silence, commits the new table/program,
// holds silence while microcode reloads, then fades back in. Also slews the mix control.
module prog_xfade #(
  parameter int GAIN_STEP      = 1,
  parameter int SETTLE_SAMPLES = 2048,
  parameter int MIX_STEP       = 4
) (
  input  logic         sys_clk,
  input  logic         rst,
  prog_xfade_if.slave  bus
);

  localparam int             CNT_W     = $clog2(SETTLE_SAMPLES) + 1;
  localparam logic [8:0]     G_STEP    = 9'(GAIN_STEP);
  localparam logic [8:0]     G_UNITY   = 9'd256;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [12:0]    M_STEP    = 13'(MIX_STEP);

  typedef enum logic [1:0] {IDLE, FADE_OUT, SETTLE, FADE_IN} state_t;

  state_t             r_state, w_state_nxt;
  logic [8:0]         r_gain, w_gain_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]         r_tbl;
  logic [5:0]         r_prog;
  logic [11:0]        r_mix, w_mix_nxt;
  logic signed [15:0] r_out_l, r_out_r;
  logic               r_valid;

  logic               w_differ;
  logic [8:0]         w_gain_dn, w_gain_up;
  logic [9:0]         w_gain_sum;
  logic signed [9:0]  w_gain_s;
  logic signed [25:0] w_prod_l, w_prod_r;
  logic [12:0]        w_mix_up, w_mix_dn, w_req_mix;
  logic               w_unused;

  assign w_differ   = (bus.req_prog != r_prog) || (bus.req_tbl != r_tbl);
  assign w_gain_dn  = (r_gain > G_STEP) ? r_gain - G_STEP : 9'd0;
  assign w_gain_sum = {1'b0, r_gain} + {1'b0, G_STEP};
  assign w_gain_up  = (w_gain_sum >= 10'd256) ? G_UNITY : w_gain_sum[8:0];

  // Zero-extended gain keeps 256 positive, so unity gain is exact even for -32768.
  assign w_gain_s = signed'({1'b0, r_gain});
  assign w_prod_l = bus.in_l * w_gain_s;
  assign w_prod_r = bus.in_r * w_gain_s;
  assign w_unused = ^{w_prod_l[25:24], w_prod_l[7:0], w_prod_r[25:24], w_prod_r[7:0]};

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_gain_nxt  = r_gain;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_gain_nxt = G_UNITY;
        if (w_differ) w_state_nxt = FADE_OUT;
      end
      FADE_OUT: begin
        if (bus.ena) w_gain_nxt = w_gain_dn;
        if (!w_differ) begin
          w_state_nxt = FADE_IN;
        end else if (bus.ena && w_gain_dn == 9'd0) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        w_gain_nxt = 9'd0;
        if (w_differ) begin
          w_cnt_nxt = '0;
        end else if (bus.ena) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) w_state_nxt = FADE_IN;
        end
      end
      FADE_IN: begin
        if (bus.ena) w_gain_nxt = w_gain_up;
        if (w_differ) begin
          w_state_nxt = FADE_OUT;
        end else if (bus.ena && w_gain_up == G_UNITY) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = SETTLE;
    endcase
  end

  // 13-bit arithmetic so the step can neither wrap past 12'hFFF nor below zero.
  assign w_req_mix = {1'b0, bus.req_mix};
  assign w_mix_up  = {1'b0, r_mix} + M_STEP;
  assign w_mix_dn  = {1'b0, r_mix} - M_STEP;

  always_comb begin
    w_mix_nxt = r_mix;
    if (r_mix < bus.req_mix) begin
      w_mix_nxt = (w_mix_up > w_req_mix) ? bus.req_mix : w_mix_up[11:0];
    end else if (r_mix > bus.req_mix) begin
      w_mix_nxt = (w_mix_dn[12] || w_mix_dn < w_req_mix) ? bus.req_mix : w_mix_dn[11:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= SETTLE;
      r_gain  <= 9'd0;
      r_cnt   <= '0;
      r_tbl   <= 2'd0;
      r_prog  <= 6'd0;
      r_mix   <= 12'h800;
      r_out_l <= '0;
      r_out_r <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gain  <= w_gain_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= bus.ena;
      // Commits happen only while silent, so a reload is never audible.
      if (r_state == SETTLE) begin
        r_tbl  <= bus.req_tbl;
        r_prog <= bus.req_prog;
      end
      if (bus.ena) begin
        r_out_l <= w_prod_l[23:8];
        r_out_r <= w_prod_r[23:8];
        r_mix   <= w_mix_nxt;
      end
    end
  end

  assign bus.out_l = r_out_l;
  assign bus.out_r = r_out_r;
  assign bus.valid = r_valid;
  assign bus.tbl   = r_tbl;
  assign bus.prog  = r_prog;
  assign bus.mix   = r_mix;

endmodule
